// File: rtl/pdm_dac_out.sv
// pdm_dac_out: first-order sigma-delta PDM output stage with a soft
// mute/unmute ramp. Incoming signed samples are attenuated by an arithmetic
// right shift that steps once every RAMP_SAMPLES accepted strobes, so
// turning audio on or off never produces an audible step.
module pdm_dac_out #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned SHIFT_MAX    = 8,
    parameter int unsigned RAMP_SAMPLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_stb,
    input  logic [WIDTH-1:0] din,
    input  logic             enable,
    output logic             pdm_out,
    output logic             active,
    output logic             muted
);

    localparam int unsigned SW = $clog2(SHIFT_MAX + 1);
    localparam int unsigned CW = (RAMP_SAMPLES > 1) ? $clog2(RAMP_SAMPLES) : 1;

    localparam logic [SW-1:0]    SHIFT_FULL = SW'(SHIFT_MAX);
    localparam logic [SW-1:0]    SHIFT_ONE  = SW'(1);
    localparam logic [CW-1:0]    CNT_LAST   = CW'(RAMP_SAMPLES - 1);
    localparam logic [WIDTH-1:0] SIGN_BIT   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAMP_UP,
        ST_RUN,
        ST_RAMP_DOWN
    } state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             pdm_q, pdm_d;
    logic             active_q, active_d;
    logic             muted_q, muted_d;

    logic [WIDTH-1:0] u;
    logic [WIDTH:0]   sum;

    // Ramp controller: state, attenuation shift and per-step strobe counter.
    // An enable reversal always wins over a step on the same edge.
    // A ramp entered already at its end value (e.g. RUN -> RAMP_DOWN -> RAMP_UP
    // at shift 0) finishes on the next edge instead of stepping past the limit.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                shift_d = SHIFT_FULL;
                cnt_d   = '0;
                if (enable) begin
                    state_d = ST_RAMP_UP;
                end
            end
            ST_RAMP_UP: begin
                if (!enable) begin
                    state_d = ST_RAMP_DOWN;
                    cnt_d   = '0;
                end else if (shift_q == '0) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (sample_stb) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        shift_d = shift_q - SHIFT_ONE;
                        if (shift_q == SHIFT_ONE) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                shift_d = '0;
                cnt_d   = '0;
                if (!enable) begin
                    state_d = ST_RAMP_DOWN;
                end
            end
            ST_RAMP_DOWN: begin
                if (enable) begin
                    state_d = ST_RAMP_UP;
                    cnt_d   = '0;
                end else if (shift_q == SHIFT_FULL) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (sample_stb) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        shift_d = shift_q + SHIFT_ONE;
                        if (shift_q == SHIFT_FULL - SHIFT_ONE) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                shift_d = SHIFT_FULL;
                cnt_d   = '0;
            end
        endcase
    end

    // Status flags follow the next state so they change on the triggering edge.
    always_comb begin
        active_d = (state_d == ST_RUN);
        muted_d  = (state_d == ST_IDLE);
    end

    // Sample register: attenuated sample on strobe (using the pre-edge shift),
    // forced to zero while idle.
    always_comb begin
        sample_d = sample_q;
        if (state_q == ST_IDLE) begin
            sample_d = '0;
        end else if (sample_stb) begin
            sample_d = $signed(din) >>> shift_q;
        end
    end

    // First-order modulator: offset-binary sample into a wrapping accumulator,
    // the carry out is the PDM bit.
    always_comb begin
        u     = sample_q ^ SIGN_BIT;
        sum   = {1'b0, acc_q} + {1'b0, u};
        acc_d = sum[WIDTH-1:0];
        pdm_d = sum[WIDTH];
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shift_q  <= SHIFT_FULL;
            cnt_q    <= '0;
            sample_q <= '0;
            acc_q    <= '0;
            pdm_q    <= 1'b0;
            active_q <= 1'b0;
            muted_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            acc_q    <= acc_d;
            pdm_q    <= pdm_d;
            active_q <= active_d;
            muted_q  <= muted_d;
        end
    end

    assign pdm_out = pdm_q;
    assign active  = active_q;
    assign muted   = muted_q;

endmodule

// File: tb/tb_pdm_dac_out.sv
// Scoreboard bench for pdm_dac_out (SHIFT_MAX = 8, RAMP_SAMPLES = 2).
// Stimulus pushes time-tagged expectations; a negedge monitor pops and checks.
`timescale 1ns/1ps
module tb_pdm_dac_out;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_stb;
    logic [15:0] din;
    logic        enable;
    logic        pdm_out;
    logic        active;
    logic        muted;

    pdm_dac_out #(
        .WIDTH       (16),
        .SHIFT_MAX   (8),
        .RAMP_SAMPLES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_stb(sample_stb),
        .din       (din),
        .enable    (enable),
        .pdm_out   (pdm_out),
        .active    (active),
        .muted     (muted)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int unsigned at;
        bit          c_pdm;
        logic        pdm;
        bit          c_st;
        logic        act;
        logic        mut;
        bit          c_reg;
        logic [15:0] smp;
        int unsigned sh;
        bit          c_cnt;
        int unsigned cnt;
    } chk_t;

    typedef struct {
        string       name;
        int unsigned first;
        int unsigned last;
        int unsigned ones;
    } win_t;

    chk_t        chk_q[$];
    win_t        win_q[$];
    int unsigned cyc        = 0;
    int unsigned n_assert   = 0;
    int unsigned n_fail     = 0;
    int unsigned ones_total = 0;
    int unsigned snap       = 0;
    bit          win_open   = 1'b0;
    int unsigned base;

    // 0x4000 >>> k, 0xC000 >>> k, 0x7FFF >>> k, indexed by k
    logic [15:0] up_tab [0:8] = '{16'h4000, 16'h2000, 16'h1000, 16'h0800, 16'h0400,
                                  16'h0200, 16'h0100, 16'h0080, 16'h0040};
    logic [15:0] dn_tab [0:7] = '{16'hC000, 16'hE000, 16'hF000, 16'hF800,
                                  16'hFC00, 16'hFE00, 16'hFF00, 16'hFF80};
    logic [15:0] ff_tab [0:8] = '{16'h7FFF, 16'h3FFF, 16'h1FFF, 16'h0FFF, 16'h07FF,
                                  16'h03FF, 16'h01FF, 16'h00FF, 16'h007F};

    // Edge counter: after the k-th rising edge cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic chk_t blank(input string nm, input int unsigned at);
        chk_t c;
        c.name  = nm;  c.at  = at;
        c.c_pdm = 1'b0; c.pdm = 1'b0;
        c.c_st  = 1'b0; c.act = 1'b0; c.mut = 1'b0;
        c.c_reg = 1'b0; c.smp = '0;   c.sh  = 0;
        c.c_cnt = 1'b0; c.cnt = 0;
        return c;
    endfunction

    task automatic push_chk(input chk_t c);
        int unsigned i = 0;
        while (i < chk_q.size() && chk_q[i].at <= c.at) i++;
        chk_q.insert(i, c);
    endtask

    task automatic exp_pdm(input string nm, input int unsigned at, input logic v);
        chk_t c = blank(nm, at);
        c.c_pdm = 1'b1; c.pdm = v;
        push_chk(c);
    endtask

    task automatic exp_st(input string nm, input int unsigned at, input logic a, input logic m);
        chk_t c = blank(nm, at);
        c.c_st = 1'b1; c.act = a; c.mut = m;
        push_chk(c);
    endtask

    task automatic exp_reg(input string nm, input int unsigned at, input logic [15:0] s,
                           input int unsigned sh);
        chk_t c = blank(nm, at);
        c.c_reg = 1'b1; c.smp = s; c.sh = sh;
        push_chk(c);
    endtask

    task automatic exp_cnt(input string nm, input int unsigned at, input int unsigned n);
        chk_t c = blank(nm, at);
        c.c_cnt = 1'b1; c.cnt = n;
        push_chk(c);
    endtask

    task automatic push_win(input string nm, input int unsigned f, input int unsigned l,
                            input int unsigned n);
        win_t w;
        w.name = nm; w.first = f; w.last = l; w.ones = n;
        win_q.push_back(w);
    endtask

    function automatic void cmp(input string nm, input string fld, input logic [31:0] act_v,
                                input logic [31:0] exp_v);
        n_assert++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s.%s: actual 0x%0h, required 0x%0h at cycle %0d",
                     nm, fld, act_v, exp_v, cyc);
        end
    endfunction

    // Monitor: ones-count windows and per-cycle checks, sampled mid-cycle.
    always @(negedge clk) begin : monitor
        chk_t c;
        if (!win_open && win_q.size() > 0) begin
            if (win_q[0].first == cyc) begin
                snap     = ones_total;
                win_open = 1'b1;
            end else if (win_q[0].first < cyc) begin
                cmp({win_q[0].name, "_missed"}, "cycle", 32'(cyc), 32'(win_q[0].first));
                void'(win_q.pop_front());
            end
        end
        if (pdm_out === 1'b1) ones_total++;
        if (win_open && win_q[0].last == cyc) begin
            cmp(win_q[0].name, "ones", 32'(ones_total - snap), 32'(win_q[0].ones));
            void'(win_q.pop_front());
            win_open = 1'b0;
        end
        while (chk_q.size() > 0 && chk_q[0].at <= cyc) begin
            c = chk_q.pop_front();
            if (c.at < cyc) begin
                cmp({c.name, "_missed"}, "cycle", 32'(cyc), 32'(c.at));
            end else begin
                if (c.c_pdm) cmp(c.name, "pdm_out", 32'(pdm_out), 32'(c.pdm));
                if (c.c_st) begin
                    cmp(c.name, "active", 32'(active), 32'(c.act));
                    cmp(c.name, "muted", 32'(muted), 32'(c.mut));
                end
                if (c.c_reg) begin
                    cmp(c.name, "sample", 32'(dut.sample_q), 32'(c.smp));
                    cmp(c.name, "shift", 32'(dut.shift_q), c.sh);
                end
                if (c.c_cnt) cmp(c.name, "cnt", 32'(dut.cnt_q), c.cnt);
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [15:0] d);
        sample_stb = 1'b1;
        din        = d;
        tick(1);
        sample_stb = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; sample_stb = 1'b0; din = '0;
        tick(3);

        // Reset state
        exp_st("rst_state", cyc, 1'b0, 1'b1);
        exp_reg("rst_regs", cyc, 16'h0000, 8);
        exp_cnt("rst_cnt", cyc, 0);
        exp_pdm("rst_pdm", cyc, 1'b0);

        // Release in IDLE: alternating 0,1,...; full-scale strobes ignored
        rst_n = 1'b1; sample_stb = 1'b1; din = 16'h7FFF;
        base = cyc;
        for (int j = 1; j <= 8; j++) begin
            exp_pdm("idle_alt", base + j, (j % 2 == 0));
            exp_st("idle_st", base + j, 1'b0, 1'b1);
            exp_reg("idle_ignore", base + j, 16'h0000, 8);
        end
        tick(8);
        sample_stb = 1'b0;

        // Ramp up, one strobe every 4 clocks
        enable = 1'b1;
        exp_st("ramp_up_enter", cyc + 1, 1'b0, 1'b0);
        exp_reg("ramp_up_enter", cyc + 1, 16'h0000, 8);
        tick(1);
        for (int s = 1; s <= 16; s++) begin
            exp_reg("ramp_up", cyc + 1, up_tab[8 - (s - 1) / 2], 8 - s / 2);
            exp_st("ramp_up_st", cyc + 1, (s == 16), 1'b0);
            strobe(16'h4000);
            tick(3);
        end

        // DC accuracy in RUN
        exp_reg("run_4000", cyc + 1, 16'h4000, 0);
        strobe(16'h4000);
        push_win("dc_4000", cyc + 2, cyc + 1025, 768);
        tick(1030);

        exp_reg("run_8000", cyc + 1, 16'h8000, 0);
        strobe(16'h8000);
        for (int j = 1; j <= 8; j++) exp_pdm("dc_8000_bit", cyc + j, 1'b0);
        push_win("dc_8000", cyc + 1, cyc + 256, 0);
        tick(260);

        exp_reg("run_7fff", cyc + 1, 16'h7FFF, 0);
        strobe(16'h7FFF);
        push_win("dc_7fff", cyc + 1, cyc + 65536, 65535);
        tick(65540);

        // Ramp down to IDLE with a negative sample
        enable = 1'b0;
        exp_st("ramp_dn_enter", cyc + 1, 1'b0, 1'b0);
        exp_reg("ramp_dn_enter", cyc + 1, 16'h7FFF, 0);
        tick(1);
        for (int s = 1; s <= 16; s++) begin
            exp_reg("ramp_dn", cyc + 1, dn_tab[(s - 1) / 2], s / 2);
            exp_st("ramp_dn_st", cyc + 1, 1'b0, (s == 16));
            strobe(16'hC000);
            tick(3);
        end
        exp_reg("idle_back", cyc, 16'h0000, 8);
        push_win("idle_back_alt", cyc + 1, cyc + 64, 32);
        tick(66);

        // Reversal mid-ramp: enable drop coincides with a would-be step
        enable = 1'b1;
        exp_st("rev_enter", cyc + 1, 1'b0, 1'b0);
        exp_cnt("rev_enter", cyc + 1, 0);
        tick(1);
        for (int s = 1; s <= 7; s++) begin
            exp_reg("rev_up", cyc + 1, up_tab[8 - (s - 1) / 2], 8 - s / 2);
            strobe(16'h4000);
            tick(1);
        end
        exp_cnt("rev_pre", cyc, 1);
        exp_reg("rev_pre", cyc, 16'h0200, 5);
        enable = 1'b0;
        exp_reg("rev_flip", cyc + 1, 16'h0200, 5);
        exp_cnt("rev_flip", cyc + 1, 0);
        exp_st("rev_flip", cyc + 1, 1'b0, 1'b0);
        strobe(16'h4000);
        tick(1);
        exp_reg("rev_dn1", cyc + 1, 16'h0200, 5);
        exp_cnt("rev_dn1", cyc + 1, 1);
        strobe(16'h4000);
        tick(1);
        exp_reg("rev_dn2", cyc + 1, 16'h0200, 6);
        exp_cnt("rev_dn2", cyc + 1, 0);
        strobe(16'h4000);
        tick(1);

        // Back up to RUN with back-to-back strobes
        enable = 1'b1;
        exp_st("b2b_enter", cyc + 1, 1'b0, 1'b0);
        exp_reg("b2b_enter", cyc + 1, 16'h0200, 6);
        tick(1);
        sample_stb = 1'b1; din = 16'h7FFF;
        base = cyc;
        for (int s = 1; s <= 12; s++) begin
            exp_reg("b2b", base + s, ff_tab[6 - (s - 1) / 2], 6 - s / 2);
            exp_st("b2b_st", base + s, (s == 12), 1'b0);
        end
        tick(12);
        sample_stb = 1'b0;
        exp_reg("run_again", cyc + 1, 16'h7FFF, 0);
        strobe(16'h7FFF);
        exp_st("run_hold", cyc + 2, 1'b1, 1'b0);
        tick(3);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        exp_st("async_rst", cyc, 1'b0, 1'b1);
        exp_pdm("async_rst", cyc, 1'b0);
        exp_reg("async_rst", cyc, 16'h0000, 8);
        exp_cnt("async_rst", cyc, 0);
        enable = 1'b0;
        tick(2);
        rst_n = 1'b1;
        base = cyc;
        for (int j = 1; j <= 4; j++) begin
            exp_pdm("post_rst_alt", base + j, (j % 2 == 0));
            exp_st("post_rst_st", base + j, 1'b0, 1'b1);
        end
        tick(6);

        for (int i = 0; i < 200 && (chk_q.size() > 0 || win_q.size() > 0); i++) @(posedge clk);
        while (chk_q.size() > 0) begin
            n_assert++; n_fail++;
            $display("FAIL %s.timeout: actual pending, required checked by cycle %0d",
                     chk_q[0].name, chk_q[0].at);
            void'(chk_q.pop_front());
        end
        while (win_q.size() > 0) begin
            n_assert++; n_fail++;
            $display("FAIL %s.timeout: actual pending, required closed by cycle %0d",
                     win_q[0].name, win_q[0].last);
            void'(win_q.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pdm_dac_out.md
# pdm_dac_out

First-order sigma-delta output stage that reads the 16-bit signed sample stream produced by the filter chain and converts it into a 1-bit PDM stream for an external RC low-pass on the output pin. It includes a soft mute/unmute ramp, an arithmetic-shift attenuation stepped per accepted sample, so enabling or disabling audio does not produce clicks. It is the final block of the audio path and runs entirely in the fast clock domain; samples arrive as a one-cycle strobe.

## Interface
- WIDTH, 16, sample width; also accumulator width.
- SHIFT_MAX, 8, attenuation shift while fully muted and at the start of ramp-up.
- RAMP_SAMPLES, 16, accepted samples per attenuation step; must be ≥1.

- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sample_stb  in  1  one-cycle strobe; `din` is valid in this cycle.
- din  in  WIDTH  signed two's-complement sample.
- enable  in  1  1 = audio on (ramp up or stay on), 0 = audio off (ramp down or stay off).
- pdm_out  out  1  registered PDM bit.
- active  out  1  registered; 1 only in RUN.
- muted  out  1  registered; 1 only in IDLE.

## Operation
- Reset values: state IDLE, shift = SHIFT_MAX, step counter = 0, sample register = 0, accumulator = 0, pdm_out = 0, active = 0, muted = 1.
- Sample register: on an edge with sample_stb = 1 it loads `din >>> shift`, an arithmetic sign-extending shift using the shift value before that edge. In IDLE it loads 0 whatever the strobe.
- Modulator, every clk: u = sample_reg XOR 2^(WIDTH-1), i.e. offset binary. Form {carry, acc} = acc + u. pdm_out <= carry. The long-run density of 1s is u/2^WIDTH.
- States and transitions. The step counter is cleared on every state change.
  - IDLE: shift held at SHIFT_MAX. If enable = 1, go to RAMP_UP.
  - RAMP_UP: the counter counts accepted strobes. When it reaches RAMP_SAMPLES it clears and shift decrements. On the edge where shift becomes 0, go to RUN. If enable = 0, go to RAMP_DOWN with shift kept.
  - RUN: shift = 0. If enable = 0, go to RAMP_DOWN.
  - RAMP_DOWN: as RAMP_UP, but shift increments. On the edge where shift becomes SHIFT_MAX, go to IDLE. If enable = 1, go to RAMP_UP with shift kept.
- Direction reversal: an enable change takes priority over a step on the same edge. The state changes, the counter clears and shift is unchanged on that edge.
- Full ramp length: SHIFT_MAX × RAMP_SAMPLES strobes. Sample arrival spacing is unconstrained; back-to-back strobes (every cycle) are legal.
- Width rules: acc is WIDTH bits and wraps modulo 2^WIDTH; carry is the bit above it. No saturation is needed.
- Reset mid-operation: every register returns to its reset value immediately, asynchronously. After release, operation starts from IDLE.

## Timing
- A strobe at edge N loads the sample register at edge N. Its first effect on pdm_out is at edge N+1. Latency: 1 clk from the strobe edge to the first affected pdm bit.
- State, shift, active and muted update on the same edge as the triggering condition. A sample strobed on a shift-changing edge uses the old shift.
- enable is sampled each edge and needs no synchronization; it comes from the same clock domain.
- IDLE output from reset (acc = 0, u = 0x8000): pdm_out = 0,1,0,1,… starting at the first edge after release.

## Test plan
- Reset/idle: hold rst_n = 0, then release with enable = 0 -> pdm_out alternates 0,1,0,1; muted = 1, active = 0; strobes with din = 0x7FFF change nothing.
- Ramp-up: RAMP_SAMPLES = 2, SHIFT_MAX = 8; enable = 1; strobe din = 0x4000 every 4 clks -> sample register takes 0x0040 for the first two strobes, then 0x0080, …; active = 1 on the edge of the 16th strobe.
- DC accuracy in RUN: din = 0x4000 held -> exactly 49152 ones in any 65536-clk window; din = 0x8000 -> pdm_out constantly 0; din = 0x7FFF -> exactly one 0 per 65536 clks.
- Ramp-down to IDLE: from RUN set enable = 0 -> shift rises 0→8 over 16 strobes; muted = 1 on the 16th strobe edge; the pattern returns to alternating.
- Reversal mid-ramp: RAMP_UP at shift = 5 with counter = 1; drop enable -> RAMP_DOWN, shift stays 5, counter = 0; the next two strobes take shift to 6.
- Async reset mid-RUN: assert rst_n = 0 between clk edges -> pdm_out = 0, active = 0, muted = 1 immediately, with no clk edge required.
